truth_table_sweeper: RTL
========================

Name: truth_table_sweeper

Overview:
- Stimulus and capture stage wrapped around one 3-input combinational logic gate, such as the 0x22 gate module.
- Upstream role: drives in1/in2/in3 through all 8 input vectors in order 000 to 111.
- Downstream role: samples the gate's output after a settle window and assembles the 8-bit truth-table word.
- Compares that word against an expected code and reports match.
- Used for on-chip self-check of each compiled gate against its hex name.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..255; an out-of-range value is an elaboration error.
- EXPECTED, 8'h22, expected truth-table word in MSB-first encoding (defined under Behaviour).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a sweep
- in1  output  1  gate input, MSB of the vector index
- in2  output  1  gate input, middle bit of the vector index
- in3  output  1  gate input, LSB of the vector index
- dut_out  input  1  gate output under test
- busy  output  1  sweep in progress
- done  output  1  sweep finished; held until next start or reset
- table_out  output  8  captured truth-table word
- match  output  1  table_out == EXPECTED; valid only while done=1

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, vector=0, so {in1,in2,in3}=000.
  - busy=0, done=0, match=0, table_out=8'h00, settle counter=0.
  - Reset has priority over every other input, including mid-sweep; any partial table is discarded.
- Encoding: for vector index v = {in1,in2,in3}, the sample is written to table_out[7-v]. So 000 maps to bit 7 and 111 maps to bit 0, which makes table_out read as the gate's hex name.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 → DRIVE, vector=0, counter=0, table_out cleared to 0, busy=1.
- DRIVE:
  - Vector is held stable.
  - Counter increments each cycle.
  - When counter == SETTLE_CYCLES-1, go to SAMPLE next.
- SAMPLE (one cycle):
  - table_out[7-v] <= dut_out.
  - If v==7 → DONE: busy=0, done=1, match registered from the completed word.
  - Otherwise vector <= v+1, counter=0, return to DRIVE.
- DONE:
  - Outputs held and vector stays at 111.
  - start=1 → same action as start in IDLE (done cleared, new sweep).
- Timing:
  - Each vector occupies exactly SETTLE_CYCLES+1 cycles.
  - From the start-sampling edge to the edge at which done rises is 8*(SETTLE_CYCLES+1) edges; 24 edges at the default.
  - Vector changes occur only on the edge leaving SAMPLE, never mid-settle.
- start while busy=1 is ignored and has no side effects.
- Same-edge rst and start: rst wins, state=IDLE.
- match is 0 whenever done=0.
- Vector counter is 3-bit. It must not wrap to 000 at the end of a sweep; it holds 111 until the next start.

Optional Feature:
- Macro: TRUTH_TABLE_SWEEPER_STABILITY_EN.
- When defined:
  - Adds output port "unstable" (1 bit, reset 0).
  - dut_out is also captured on the last DRIVE cycle of each vector.
  - If that capture differs from the SAMPLE-cycle value, unstable is set and held until the next start or reset.
  - match is forced to 0 when unstable=1.
- When undefined:
  - No unstable port and no extra flops.
  - match depends only on table_out.

Decomposition:
- Shared package truth_table_pkg holds:
  - FSM state enum (IDLE, DRIVE, SAMPLE, DONE).
  - Constant NUM_VECTORS=8.
  - Function vec_to_bit(v) returning 7-v.
  - Named gate-code constants, e.g. GATE_0X22=8'h22.
- Optional sub-module settle_counter: a parameterised down-counter with load and expire pulse, instantiated once.

Test Plan:
- Default params, dut_out = in2 & ~in3, pulse start → after 24 cycles done=1, table_out=8'h22, match=1, busy=0.
- dut_out tied to 1, EXPECTED=8'h22 → table_out=8'hFF, match=0; then a second start → done drops next cycle, and 24 cycles later done=1 again with the same result.
- SETTLE_CYCLES=1 → done rises 16 cycles after start; in1/in2/in3 step 000→111 every 2 cycles.
- start pulsed at cycles 5 and 10 of a running sweep → no restart, done still at cycle 24, result unchanged.
- rst asserted at cycle 12 mid-sweep → next cycle all outputs at reset values with {in1,in2,in3}=000; a new start gives a correct full result.
- With TRUTH_TABLE_SWEEPER_STABILITY_EN, dut_out flips on the sample edge of vector 3 → unstable=1, match=0 at done.

Source files
------------

// File: rtl/truth_table_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state type, vector
// count, vector-index to table-bit mapping and named gate codes.
package truth_table_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      DONE
   } state_t;

   localparam int unsigned NUM_VECTORS = 8;

   localparam logic [7:0] GATE_0X00 = 8'h00;
   localparam logic [7:0] GATE_0X22 = 8'h22;
   localparam logic [7:0] GATE_0X80 = 8'h80;
   localparam logic [7:0] GATE_0X96 = 8'h96;
   localparam logic [7:0] GATE_0XFE = 8'hFE;

   // Vector 000 lands in bit 7, 111 in bit 0, so the word reads as the hex name.
   function automatic logic [2:0] vec_to_bit(input logic [2:0] v);
      return 3'd7 - v;
   endfunction

endpackage

// File: rtl/settle_counter.sv
// Down-counter used to time the settle window of each vector.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (count -> 0)
//   load     load load_val (has priority over counting)
//   en       count enable; count decrements while non-zero
//   load_val value loaded on load
//   expire   high while enabled and the count has reached zero
module settle_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] load_val,
   output logic             expire
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign expire = en && (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives a 3-input gate through vectors 000..111, samples its output after a
// settle window, assembles the MSB-first truth-table word and compares it with
// EXPECTED.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      one-cycle sweep request (ignored while busy)
//   in1/in2/in3 gate inputs, MSB..LSB of the vector index
//   dut_out    gate output under test
//   busy       sweep in progress
//   done       sweep finished, held until next start or reset
//   table_out  captured truth-table word
//   match      table_out == EXPECTED, only while done
//   unstable   (only with TRUTH_TABLE_SWEEPER_STABILITY_EN) output changed
//              between the last settle cycle and the sample cycle
// Optional feature macro: TRUTH_TABLE_SWEEPER_STABILITY_EN
module truth_table_sweeper
   import truth_table_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [7:0]  EXPECTED      = GATE_0X22
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   input  logic       dut_out,
   output logic       busy,
   output logic       done,
   output logic [7:0] table_out,
`ifdef TRUTH_TABLE_SWEEPER_STABILITY_EN
   output logic       unstable,
`endif
   output logic       match
);

   if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 255)) begin : g_bad_settle
      $error("truth_table_sweeper: SETTLE_CYCLES must be in 1..255");
   end

   localparam logic [7:0] LOAD_VAL = 8'(SETTLE_CYCLES - 1);
   localparam logic [2:0] LAST_VEC = 3'(NUM_VECTORS - 1);

   state_t     state;
   logic [2:0] vec;
   logic [7:0] next_table;
   logic       start_ok;
   logic       cnt_load;
   logic       expire;
   logic       word_ok;

   assign {in1, in2, in3} = vec;
   assign start_ok = start && ((state == IDLE) || (state == DONE));
   assign cnt_load = start_ok || ((state == SAMPLE) && (vec != LAST_VEC));

   always_comb begin
      next_table = table_out;
      next_table[vec_to_bit(vec)] = dut_out;
   end

`ifdef TRUTH_TABLE_SWEEPER_STABILITY_EN
   logic last_drive;
   logic unstable_next;
   assign unstable_next = unstable || (dut_out != last_drive);
   assign word_ok = (next_table == EXPECTED) && !unstable_next;
`else
   assign word_ok = (next_table == EXPECTED);
`endif

   settle_counter #(
      .WIDTH(8)
   ) u_settle (
      .clk     (clk),
      .rst     (rst),
      .load    (cnt_load),
      .en      (state == DRIVE),
      .load_val(LOAD_VAL),
      .expire  (expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         vec       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         match     <= 1'b0;
         table_out <= '0;
`ifdef TRUTH_TABLE_SWEEPER_STABILITY_EN
         unstable   <= 1'b0;
         last_drive <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= DRIVE;
                  vec       <= '0;
                  table_out <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  match     <= 1'b0;
`ifdef TRUTH_TABLE_SWEEPER_STABILITY_EN
                  unstable  <= 1'b0;
`endif
               end
            end
            DRIVE: begin
               if (expire) begin
                  state <= SAMPLE;
`ifdef TRUTH_TABLE_SWEEPER_STABILITY_EN
                  last_drive <= dut_out;
`endif
               end
            end
            SAMPLE: begin
               table_out <= next_table;
`ifdef TRUTH_TABLE_SWEEPER_STABILITY_EN
               unstable  <= unstable_next;
`endif
               if (vec == LAST_VEC) begin
                  // vec is left at 111 so the gate inputs do not wrap.
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  match <= word_ok;
               end else begin
                  vec   <= vec + 3'd1;
                  state <= DRIVE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
